// File: rtl/cbm2_seg6509.sv
// 6509 execution/indirection segment registers at $0000/$0001, read-back override and (zp),Y tracking.
// Combinational cpuSeg/cpuDi from registered state; register writes visible from the next bus cycle; no backpressure, cpu_ce-paced.
module cbm2_seg6509 #(
  parameter int         SEG_BITS  = 4,
  parameter logic [7:0] RESET_SEG = 8'h0F
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDo,
  input  logic        cpuWe,
  input  logic        cpuSync,
  input  logic [7:0]  busDi,
  output logic [7:0]  cpuSeg,
  output logic [7:0]  cpuDi,
  output logic [7:0]  execSeg,
  output logic [7:0]  indSeg
);

  typedef enum logic {
    IDLE = 1'b0,
    OPND = 1'b1
  } state_t;

  logic [SEG_BITS-1:0] exec_q;
  logic [SEG_BITS-1:0] ind_q;
  state_t              state_q;
  state_t              state_d;
  logic [2:0]          cnt_q;
  logic [2:0]          cnt_d;

  logic [7:0] exec_z;
  logic [7:0] ind_z;
  logic       sel_exec;
  logic       sel_ind;
  logic       opc_match;
  logic       ind_active;
  logic       unused_do_bits;

  // Only the low SEG_BITS of the written byte are stored.
  assign unused_do_bits = ^cpuDo;

  always_comb begin
    exec_z = '0;
    ind_z  = '0;
    exec_z[SEG_BITS-1:0] = exec_q;
    ind_z[SEG_BITS-1:0]  = ind_q;
  end

  assign sel_exec = (cpuAddr == 16'h0000);
  assign sel_ind  = (cpuAddr == 16'h0001);

  always_comb begin
    cpuDi = busDi;
    if (sel_exec) begin
      cpuDi = exec_z;
    end else if (sel_ind) begin
      cpuDi = ind_z;
    end
  end

  // Opcode decode uses the overridden byte so fetches from $0000/$0001 see the registers.
  assign opc_match = (cpuDi == 8'hB1) || (cpuDi == 8'h91);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      exec_q <= RESET_SEG[SEG_BITS-1:0];
      ind_q  <= RESET_SEG[SEG_BITS-1:0];
    end else if (cpu_ce && cpuWe) begin
      if (sel_exec) begin
        exec_q <= cpuDo[SEG_BITS-1:0];
      end
      if (sel_ind) begin
        ind_q <= cpuDo[SEG_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cpu_ce) begin
      case (state_q)
        IDLE: begin
          if (cpuSync && opc_match) begin
            state_d = OPND;
            cnt_d   = 3'd1;
          end
        end
        OPND: begin
          if (cpuSync) begin
            if (opc_match) begin
              state_d = OPND;
              cnt_d   = 3'd1;
            end else begin
              state_d = IDLE;
              cnt_d   = 3'd0;
            end
          end else if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // cnt counts bus cycles since the opcode fetch: 4 means the 5th cycle, the first data access.
  assign ind_active = (state_q == OPND) && (cnt_q >= 3'd4) && !cpuSync;

  assign cpuSeg  = ind_active ? ind_z : exec_z;
  assign execSeg = exec_z;
  assign indSeg  = ind_z;

endmodule

// File: tb/tb_cbm2_seg6509.sv
// Directed bench for cbm2_seg6509: register access, read override and (zp),Y segment sequencing.
module tb_cbm2_seg6509;

  logic        clk_sys;
  logic        reset;
  logic        cpu_ce;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDo;
  logic        cpuWe;
  logic        cpuSync;
  logic [7:0]  busDi;
  logic [7:0]  cpuSeg;
  logic [7:0]  cpuDi;
  logic [7:0]  execSeg;
  logic [7:0]  indSeg;

  int checks = 0;
  int errors = 0;

  cbm2_seg6509 #(.SEG_BITS(4), .RESET_SEG(8'h0F)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cpu_ce  (cpu_ce),
    .cpuAddr (cpuAddr),
    .cpuDo   (cpuDo),
    .cpuWe   (cpuWe),
    .cpuSync (cpuSync),
    .busDi   (busDi),
    .cpuSeg  (cpuSeg),
    .cpuDi   (cpuDi),
    .execSeg (execSeg),
    .indSeg  (indSeg)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // One bus cycle: present inputs, check cpuSeg mid-cycle, then end it with a cpu_ce strobe.
  task automatic bus_cycle(input logic [15:0] addr, input logic sync, input logic we,
                           input logic [7:0] dout, input logic [7:0] bdi,
                           input logic [7:0] exp_seg, input string tag);
    cpuAddr = addr;
    cpuSync = sync;
    cpuWe   = we;
    cpuDo   = dout;
    busDi   = bdi;
    cpu_ce  = 1'b0;
    @(posedge clk_sys);
    #1;
    check(tag, cpuSeg, exp_seg);
    cpu_ce = 1'b1;
    @(posedge clk_sys);
    #1;
    cpu_ce  = 1'b0;
    cpuWe   = 1'b0;
    cpuSync = 1'b0;
  endtask

  task automatic set_idle_addr(input logic [15:0] addr, input logic [7:0] bdi);
    cpuAddr = addr;
    busDi   = bdi;
    cpuWe   = 1'b0;
    cpuSync = 1'b0;
    cpu_ce  = 1'b0;
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    cpu_ce  = 1'b0;
    cpuAddr = 16'h0000;
    cpuDo   = 8'h00;
    cpuWe   = 1'b0;
    cpuSync = 1'b0;
    busDi   = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;

    // Reset state and read override.
    set_idle_addr(16'h0000, 8'h55);
    check("rst_exec", execSeg, 8'h0F);
    check("rst_ind", indSeg, 8'h0F);
    check("rst_seg", cpuSeg, 8'h0F);
    check("rd_0000", cpuDi, 8'h0F);
    set_idle_addr(16'h0001, 8'h55);
    check("rd_0001", cpuDi, 8'h0F);
    set_idle_addr(16'h0002, 8'hAA);
    check("rd_0002", cpuDi, 8'hAA);

    // exec write, visible from the next cycle.
    bus_cycle(16'h0000, 1'b0, 1'b1, 8'h31, 8'h00, 8'h0F, "wr_exec_seg");
    check("exec_after_wr", execSeg, 8'h01);
    check("ind_unchanged", indSeg, 8'h0F);
    bus_cycle(16'h1000, 1'b1, 1'b0, 8'h00, 8'hEA, 8'h01, "fetch_seg1");
    set_idle_addr(16'h0000, 8'h77);
    check("rd_exec_1", cpuDi, 8'h01);

    bus_cycle(16'h0001, 1'b0, 1'b1, 8'h03, 8'h00, 8'h01, "wr_ind_seg");
    check("ind_after_wr", indSeg, 8'h03);
    set_idle_addr(16'h0001, 8'h77);
    check("rd_ind_3", cpuDi, 8'h03);

    // LDA ($20),Y without page cross.
    bus_cycle(16'h1001, 1'b1, 1'b0, 8'h00, 8'hB1, 8'h01, "lda_c1");
    bus_cycle(16'h1002, 1'b0, 1'b0, 8'h00, 8'h20, 8'h01, "lda_c2");
    bus_cycle(16'h0020, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, "lda_c3");
    bus_cycle(16'h0021, 1'b0, 1'b0, 8'h00, 8'h30, 8'h01, "lda_c4");
    set_idle_addr(16'h3005, 8'h5A);
    check("lda_c5_di", cpuDi, 8'h5A);
    bus_cycle(16'h3005, 1'b0, 1'b0, 8'h00, 8'h5A, 8'h03, "lda_c5");
    bus_cycle(16'h1003, 1'b1, 1'b0, 8'h00, 8'hEA, 8'h01, "lda_next_sync");
    bus_cycle(16'h1004, 1'b0, 1'b0, 8'h00, 8'hEA, 8'h01, "nop_c2");

    // LDA ($20),Y with page cross.
    bus_cycle(16'h1005, 1'b1, 1'b0, 8'h00, 8'hB1, 8'h01, "ldx_c1");
    bus_cycle(16'h1006, 1'b0, 1'b0, 8'h00, 8'h20, 8'h01, "ldx_c2");
    bus_cycle(16'h0020, 1'b0, 1'b0, 8'h00, 8'hF0, 8'h01, "ldx_c3");
    bus_cycle(16'h0021, 1'b0, 1'b0, 8'h00, 8'h30, 8'h01, "ldx_c4");
    bus_cycle(16'h3005, 1'b0, 1'b0, 8'h00, 8'h11, 8'h03, "ldx_c5");
    bus_cycle(16'h3105, 1'b0, 1'b0, 8'h00, 8'h22, 8'h03, "ldx_c6");

    // STA ($20),Y then LDA $20,X.
    bus_cycle(16'h1007, 1'b1, 1'b0, 8'h00, 8'h91, 8'h01, "sta_c1");
    bus_cycle(16'h1008, 1'b0, 1'b0, 8'h00, 8'h20, 8'h01, "sta_c2");
    bus_cycle(16'h0020, 1'b0, 1'b0, 8'h00, 8'hF0, 8'h01, "sta_c3");
    bus_cycle(16'h0021, 1'b0, 1'b0, 8'h00, 8'h30, 8'h01, "sta_c4");
    bus_cycle(16'h3005, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03, "sta_c5");
    bus_cycle(16'h3105, 1'b0, 1'b1, 8'h42, 8'h00, 8'h03, "sta_c6_wr");
    check("sta_exec_kept", execSeg, 8'h01);
    check("sta_ind_kept", indSeg, 8'h03);
    bus_cycle(16'h1009, 1'b1, 1'b0, 8'h00, 8'hB5, 8'h01, "ldzx_c1");
    bus_cycle(16'h100A, 1'b0, 1'b0, 8'h00, 8'h20, 8'h01, "ldzx_c2");
    bus_cycle(16'h0020, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, "ldzx_c3");
    bus_cycle(16'h0021, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, "ldzx_c4");

    // Back-to-back B1 fetches must re-arm the count.
    bus_cycle(16'h100B, 1'b1, 1'b0, 8'h00, 8'hB1, 8'h01, "b2b_op1");
    bus_cycle(16'h100C, 1'b0, 1'b0, 8'h00, 8'h20, 8'h01, "b2b_c2a");
    bus_cycle(16'h100D, 1'b0, 1'b0, 8'h00, 8'h20, 8'h01, "b2b_c3a");
    bus_cycle(16'h100E, 1'b1, 1'b0, 8'h00, 8'hB1, 8'h01, "b2b_op2");
    bus_cycle(16'h100F, 1'b0, 1'b0, 8'h00, 8'h20, 8'h01, "b2b_c2");
    bus_cycle(16'h0020, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, "b2b_c3");
    bus_cycle(16'h0021, 1'b0, 1'b0, 8'h00, 8'h30, 8'h01, "b2b_c4");
    bus_cycle(16'h3005, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03, "b2b_c5");

    // Reset during cycle 5 of LDA (zp),Y, coincident with cpu_ce.
    bus_cycle(16'h1010, 1'b1, 1'b0, 8'h00, 8'hB1, 8'h01, "rst_c1");
    bus_cycle(16'h1011, 1'b0, 1'b0, 8'h00, 8'h20, 8'h01, "rst_c2");
    bus_cycle(16'h0020, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, "rst_c3");
    bus_cycle(16'h0021, 1'b0, 1'b0, 8'h00, 8'h30, 8'h01, "rst_c4");
    set_idle_addr(16'h3005, 8'h00);
    check("rst_c5_seg", cpuSeg, 8'h03);
    @(posedge clk_sys);
    #1;
    reset  = 1'b1;
    cpu_ce = 1'b1;
    @(posedge clk_sys);
    #1;
    reset  = 1'b0;
    cpu_ce = 1'b0;
    check("mid_rst_seg", cpuSeg, 8'h0F);
    check("mid_rst_exec", execSeg, 8'h0F);
    check("mid_rst_ind", indSeg, 8'h0F);
    // With exec and ind different, non-sync cycles must stay on exec if the FSM is idle.
    bus_cycle(16'h0000, 1'b0, 1'b1, 8'h01, 8'h00, 8'h0F, "post_rst_wr0");
    bus_cycle(16'h0001, 1'b0, 1'b1, 8'h03, 8'h00, 8'h01, "post_rst_wr1");
    bus_cycle(16'h3005, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, "post_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/cbm2_seg6509.md
# cbm2_seg6509

Segment-register unit for the 6509 CPU, placed between the T65 core and `cbm2_buslogic`. It holds the execution and indirection segment registers, which are memory-mapped at $0000/$0001 in every segment. It overrides CPU reads of those two addresses and tracks `LDA (zp),Y` / `STA (zp),Y` so that their data accesses use the indirection segment. It produces the `cpuSeg` and final `cpuDi` seen by the bus logic and the CPU.

## Interface
Parameters:
- `SEG_BITS`, 4: implemented width of each segment register (1..8). Bits above it are zero in `cpuSeg` and in read-back.
- `RESET_SEG`, 4'hF: reset value of both registers (truncated to `SEG_BITS`).

Ports:
- `clk_sys`  in  1  system clock. The only clock.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_ce`  in  1  one-`clk_sys` strobe that ends the current CPU bus cycle. The CPU samples data and advances on this strobe.
- `cpuAddr`  in  16  CPU address, stable for the whole bus cycle.
- `cpuDo`  in  8  CPU write data.
- `cpuWe`  in  1  CPU write strobe, qualified by `cpu_ce`.
- `cpuSync`  in  1  high during opcode-fetch cycles.
- `busDi`  in  8  read data from `cbm2_buslogic` (`cpuDi`).
- `cpuSeg`  out  8  segment for the current bus cycle, to `cbm2_buslogic`.
- `cpuDi`  out  8  read data to the CPU.
- `execSeg`  out  8  execution register, zero-extended (debug/status).
- `indSeg`  out  8  indirection register, zero-extended (debug/status).

## Operation
- Registers:
  - `exec` holds the execution segment; `ind` holds the indirection segment.
  - A write with `cpu_ce & cpuWe & cpuAddr==16'h0000` loads `exec <= cpuDo[SEG_BITS-1:0]`.
  - A write to 16'h0001 loads `ind` the same way.
  - Writes are decoded regardless of the current segment.
  - The write also propagates to the bus unchanged. The RAM at seg:$0000/$0001 is never read back.
- Read override: `cpuDi = (cpuAddr==0) ? zext(exec) : (cpuAddr==1) ? zext(ind) : busDi`. This is combinational and applies in every segment, including opcode fetches.
- Indirect tracker FSM, states `IDLE`, `OPND`:
  - `IDLE`: on `cpu_ce & cpuSync`, if `cpuDi` (after override) is 8'hB1 or 8'h91, go to `OPND` and set `cnt <= 1`. Otherwise stay.
  - `OPND`: on each `cpu_ce`, `cnt <= cnt+1` (3-bit, saturating at 7).
    - On `cpu_ce & cpuSync`, re-evaluate the opcode exactly as in `IDLE`: go to `OPND` with `cnt <= 1` if it matches, else go to `IDLE`.
  - `ind_active = (state==OPND) & (cnt>=4) & ~cpuSync`.
- Segment select: `cpuSeg = zext(ind_active ? ind : exec)`.
  - Cycle 1 (opcode), cycle 2 (zp operand) and cycles 3–4 (pointer lo/hi) use `exec`.
  - Cycle 5 and later use `ind`. For LDA this covers the page-cross dummy read and the data read. For STA it covers the dummy read and the write.
- Interrupts: no `cpuSync` occurs during an interrupt sequence. An interrupt taken after an indirect opcode finishes begins only after the next `cpuSync`, so no special case is needed.

## Timing
- Reset values: `exec = ind = RESET_SEG`, FSM `IDLE`, `cnt = 0`. Hence `cpuSeg = execSeg = indSeg = zext(RESET_SEG)` (8'h0F by default). `cpuDi` follows the combinational rule.
- Reset takes priority over every `cpu_ce` event in the same clock. Reset in the middle of an instruction returns the FSM to `IDLE`.
- Register write latency: the new value appears on `execSeg`/`indSeg`/`cpuSeg` on the clock after the `cpu_ce` edge, i.e. from the next bus cycle.
  - A write to `exec` during cycle N changes the segment of cycle N+1 onward.
  - A write to `ind` during a cycle-5 STA takes effect only for later accesses.
- `cpuSeg` and `cpuDi` are combinational from registered state and the current address. They are valid all cycle and change only at `cpu_ce` edges or on address change.
- Between `cpu_ce` strobes all state holds; `cnt` advances only on `cpu_ce`.

## Test plan
- Reset then read $0000 and $0001 → `cpuDi` = 8'h0F, 8'h0F; `cpuSeg` = 8'h0F. With `busDi` = 8'hAA at address $0002 → `cpuDi` = 8'hAA.
- Write 8'h31 to $0000 in seg 15 → `execSeg` = 8'h01 from the next cycle. A following opcode fetch at $1000 presents `cpuSeg` = 8'h01. Read $0000 → 8'h01.
- Set exec = 1, ind = 3. Run `LDA ($20),Y` with no page cross (5 cycles) → `cpuSeg` sequence 1,1,1,1,3, then 1 on the next sync.
- Same with a page cross (6 cycles) → 1,1,1,1,3,3.
- `STA ($20),Y` (6 cycles) → 1,1,1,1,3,3 with the write in seg 3. Then `LDA $20,X` (opcode 8'hB5) → all cycles seg 1.
- Assert `reset` during cycle 5 of `LDA (zp),Y` with ind = 3 → next clock `cpuSeg` = 8'h0F and FSM `IDLE`. Back-to-back B1 opcodes re-arm `cnt` = 1 at each sync.
